median_ins_sequencer: RTL

Upstream feeder for the FIFO-based sorted-cell median array. It buffers incoming samples, paces insertions into the cell chain at the rate the 2-comparator cells accept them, and tracks window age. Age tracking uses a circular one-hot slot pointer, and each cell compares it against its stored tag to form its `Ti` input. It also tracks the fill/run window state and emits a median-valid strobe aligned to the array's output.

---
 rtl/median_pkg.sv | 30 +++
 rtl/median_in_fifo.sv | 58 +++++
 rtl/median_ins_sequencer.sv | 132 +++++++++++++
 3 files changed

// File: rtl/median_pkg.sv
// ============================================================================
//  Module      : median_pkg
//  Description : Shared constants, state encoding and helpers for the
//                sorted-cell median array and its insertion sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package median_pkg;

    localparam int c_DEF_W = 8;
    localparam int c_DEF_N = 9;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_FILL = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;

    // Ceiling log2, usable in constant expressions (clog2(1) = 0).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/median_in_fifo.sv
// ============================================================================
//  Module      : median_in_fifo
//  Description : Synchronous FIFO with wrap-bit pointers and full/empty flags.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module median_in_fifo
    import median_pkg::*;
#(
    parameter int W     = c_DEF_W,
    parameter int DEPTH = 4          // power of two, at least 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_push,
    input  logic         i_pop,
    input  logic [W-1:0] i_wr_data,
    output logic [W-1:0] o_rd_data,
    output logic         o_full,
    output logic         o_empty
);

    localparam int c_AW = clog2(DEPTH);

    logic [c_AW:0]  r_wr_ptr;
    logic [c_AW:0]  r_rd_ptr;
    logic [W-1:0]   r_mem [DEPTH];
    logic           w_push;
    logic           w_pop;

    assign w_push = i_push & ~o_full;
    assign w_pop  = i_pop & ~o_empty;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_wr_data;
    end

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);

    // Stale storage is masked so an empty FIFO always presents zero.
    assign o_rd_data = o_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

endmodule

`default_nettype wire

// File: rtl/median_ins_sequencer.sv
// ============================================================================
//  Module      : median_ins_sequencer
//  Description : Buffers samples, paces insertions into the median cell chain,
//                tracks age slots and window fill, and strobes median-valid.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module median_ins_sequencer
    import median_pkg::*;
#(
    parameter int W       = c_DEF_W,
    parameter int N       = c_DEF_N,   // odd, at least 3
    parameter int DEPTH   = 4,
    parameter int INS_GAP = 2,         // at least 1
    parameter int PIPE    = 2          // at least 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [W-1:0]          in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [W-1:0]          ins_data,
    output logic                  ins_stb,
    output logic                  ins_evict,
    output logic [N-1:0]          tok,
    output logic [clog2(N)-1:0]   tok_idx,
    output logic [clog2(N+1)-1:0] fill_cnt,
    output logic                  win_full,
    output logic                  med_valid
);

    localparam int c_IW = clog2(N);
    localparam int c_FW = clog2(N + 1);
    localparam int c_GW = clog2(INS_GAP + 1);

    localparam logic [c_IW-1:0] c_TOK_LAST = c_IW'(N - 1);
    localparam logic [c_FW-1:0] c_FILL_MAX = c_FW'(N);
    localparam logic [c_GW-1:0] c_GAP_LOAD = c_GW'(INS_GAP - 1);

    logic [1:0]      r_state,   w_state_nxt;
    logic [c_FW-1:0] r_fill,    w_fill_nxt;
    logic [c_IW-1:0] r_tok_idx, w_tok_nxt;
    logic [c_GW-1:0] r_gap,     w_gap_nxt;
    logic [PIPE-1:0] r_med_sr;
    logic            w_full_ins;
    logic            w_fifo_full;
    logic            w_fifo_empty;
    logic            w_stb;

    median_in_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .i_push    (in_valid),
        .i_pop     (w_stb),
        .i_wr_data (in_data),
        .o_rd_data (ins_data),
        .o_full    (w_fifo_full),
        .o_empty   (w_fifo_empty)
    );

    // A flush (or reset) suppresses a coincident insertion so the sample stays queued.
    assign w_stb = ~rst & ~flush & ~w_fifo_empty & (r_gap == '0);

    always_comb begin
        w_state_nxt = r_state;
        w_fill_nxt  = r_fill;
        w_tok_nxt   = r_tok_idx;
        w_gap_nxt   = r_gap;
        w_full_ins  = 1'b0;
        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_fill_nxt  = '0;
            w_tok_nxt   = '0;
            w_gap_nxt   = '0;
        end else if (w_stb) begin
            w_gap_nxt = c_GAP_LOAD;
            w_tok_nxt = (r_tok_idx == c_TOK_LAST) ? '0 : r_tok_idx + 1'b1;
            if (r_state == ST_RUN) begin
                w_full_ins = 1'b1;
            end else begin
                w_fill_nxt = r_fill + 1'b1;
                if (w_fill_nxt == c_FILL_MAX) begin
                    w_state_nxt = ST_RUN;
                    w_full_ins  = 1'b1;
                end else begin
                    w_state_nxt = ST_FILL;
                end
            end
        end else if (r_gap != '0) begin
            w_gap_nxt = r_gap - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_fill    <= '0;
            r_tok_idx <= '0;
            r_gap     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_fill    <= w_fill_nxt;
            r_tok_idx <= w_tok_nxt;
            r_gap     <= w_gap_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_med_sr <= '0;
        end else begin
            r_med_sr <= (r_med_sr << 1) | PIPE'(w_full_ins);
        end
    end

    assign in_ready  = ~w_fifo_full;
    assign ins_stb   = w_stb;
    assign ins_evict = (r_state == ST_RUN);
    assign tok_idx   = r_tok_idx;
    assign tok       = {{(N-1){1'b0}}, 1'b1} << r_tok_idx;
    assign fill_cnt  = r_fill;
    assign win_full  = (r_fill == c_FILL_MAX);
    assign med_valid = r_med_sr[PIPE-1];

endmodule

`default_nettype wire
